// File: rtl/shift_left_pipe.sv
// -----------------------------------------------------------------------------
// shift_left_pipe
//
// Pipelined, elastic left shifter / rotator for the multi-cycle shift path of
// the execute stage. It is the left-direction counterpart of the ALU's
// combinational right-logical shifter.
//
// Stage k (k = 0..CNT_W-1) shifts its operand left by 2^k when count bit k is
// set. It fills with zeros when Rot=0, or wraps the upper bits around when
// Rot=1. Each stage is a register slice with a valid bit. The count and the
// Rot flag travel with the data, so every stage sees the controls of its own
// operand.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all stage state
//   in_valid   In/Cnt/Rot carry an operand this cycle
//   in_ready   pipeline accepts an operand this cycle
//   In         operand, WIDTH bits
//   Cnt        shift amount, 0..WIDTH-1
//   Rot        0 = shift left logical, 1 = rotate left
//   out_valid  Out holds a valid result
//   out_ready  downstream consumes Out this cycle
//   Out        result, WIDTH bits, driven straight from the last stage register
//
// CNT_W must equal log2(WIDTH). It sets the number of stages and therefore the
// number of operations that can be in flight.
// -----------------------------------------------------------------------------
module shift_left_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic             Rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out
);

    // Per-stage state. Index k holds the operand after shift step k.
    logic [CNT_W-1:0] vReg;
    logic [WIDTH-1:0] dReg   [CNT_W];
    logic [CNT_W-1:0] cntReg [CNT_W];
    logic             rotReg [CNT_W];

    // rdy[k] means stage k may load this cycle. rdy[CNT_W] is the downstream
    // consumer. The chain is evaluated from the output end backwards, so a
    // full pipeline can still accept a new operand in the same cycle that
    // the head result leaves. A single process keeps the chain free of
    // combinational feedback between separate nets.
    logic [CNT_W:0] rdy;

    always_comb begin
        rdy        = '0;
        rdy[CNT_W] = out_ready;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            rdy[k] = ~vReg[k] | rdy[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_stage
            localparam int SH = 1 << gi;

            logic             sValid;
            logic [WIDTH-1:0] sData;
            logic [CNT_W-1:0] sCnt;
            logic             sRot;
            logic [WIDTH-1:0] sShift;

            // Stage 0 is fed from the ports. Later stages are fed from the
            // previous stage's registers.
            if (gi == 0) begin : g_head
                assign sValid = in_valid;
                assign sData  = In;
                assign sCnt   = Cnt;
                assign sRot   = Rot;
            end else begin : g_body
                assign sValid = vReg[gi-1];
                assign sData  = dReg[gi-1];
                assign sCnt   = cntReg[gi-1];
                assign sRot   = rotReg[gi-1];
            end

            // Shift by the fixed amount 2^gi. For a rotate, the bits shifted
            // out at the top are ORed back in at the bottom.
            always_comb begin
                sShift = sData;
                if (sCnt[gi]) begin
                    if (sRot) begin
                        sShift = (sData << SH) | (sData >> (WIDTH - SH));
                    end else begin
                        sShift = sData << SH;
                    end
                end
            end

            // A stage loads whenever it is allowed to. If the upstream stage
            // is empty, the stage loads a bubble (valid = 0). If the stage
            // cannot load, it holds its contents unchanged.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vReg[gi]   <= 1'b0;
                    dReg[gi]   <= '0;
                    cntReg[gi] <= '0;
                    rotReg[gi] <= 1'b0;
                end else if (rdy[gi]) begin
                    vReg[gi]   <= sValid;
                    dReg[gi]   <= sShift;
                    cntReg[gi] <= sCnt;
                    rotReg[gi] <= sRot;
                end
            end
        end
    endgenerate

    assign in_ready  = rdy[0];
    assign out_valid = vReg[CNT_W-1];
    assign Out       = dReg[CNT_W-1];

endmodule
